// File: rtl/round_robin_arbiter_4.sv
// round_robin_arbiter_4: four-requester round-robin arbiter with registered grant.
// A new owner is chosen by searching from the priority pointer, and the grant is
// held until the owner drops its request.
// Optional tenure limiting is compiled in with macro HOLD_LIMIT_EN: an owner that
// has held the grant for HOLD_MAX cycles yields to any other pending requester.
module round_robin_arbiter_4 #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid
);

  localparam int unsigned N_REQ = 4;
  localparam int unsigned IDX_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] ptr_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic             valid_nxt;
  logic [N_REQ-1:0] gnt_nxt;
  logic             grant_new;
  logic [IDX_W:0]   pick_all;
  logic             owner_req;

`ifdef HOLD_LIMIT_EN
  localparam int unsigned CNT_W = $clog2(HOLD_MAX);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(HOLD_MAX - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [IDX_W:0]   pick_other;
  logic [N_REQ-1:0] owner_mask;
  logic             at_limit;
`endif

  // Round-robin search: returns {found, index} of the first set bit at or after start.
  function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] mask,
                                             input logic [IDX_W-1:0] start);
    logic [IDX_W:0]   res;
    logic [IDX_W-1:0] cand;
    res = '0;
    // Walk from the farthest offset down so the closest candidate wins last.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = start + IDX_W'(k);
      if (mask[cand]) begin
        res = {1'b1, cand};
      end
    end
    return res;
  endfunction

  // Candidate winners for the current cycle.
  always_comb begin
    pick_all  = rr_pick(req, ptr);
    owner_req = req[gnt_idx];
`ifdef HOLD_LIMIT_EN
    owner_mask = N_REQ'(1) << gnt_idx;
    pick_other = rr_pick(req & ~owner_mask, ptr);
    at_limit   = (cnt == CNT_LIM);
`endif
  end

  // Next-state, next-owner and pointer decision.
  always_comb begin
    state_nxt = state;
    idx_nxt   = gnt_idx;
    valid_nxt = gnt_valid;
    ptr_nxt   = ptr;
    grant_new = 1'b0;

    case (state)
      IDLE: begin
        valid_nxt = 1'b0;
        if (pick_all[IDX_W]) begin
          state_nxt = GRANT;
          idx_nxt   = pick_all[IDX_W-1:0];
          grant_new = 1'b1;
        end
      end

      GRANT: begin
        if (!owner_req) begin
          // Owner released: hand over without a bubble, or fall back to idle.
          if (pick_all[IDX_W]) begin
            idx_nxt   = pick_all[IDX_W-1:0];
            grant_new = 1'b1;
          end else begin
            state_nxt = IDLE;
            valid_nxt = 1'b0;
          end
        end
`ifdef HOLD_LIMIT_EN
        else if (at_limit && pick_other[IDX_W]) begin
          // Tenure expired and someone else is waiting: force a handover.
          idx_nxt   = pick_other[IDX_W-1:0];
          grant_new = 1'b1;
        end
`endif
      end

      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
      end
    endcase

    if (grant_new) begin
      valid_nxt = 1'b1;
      ptr_nxt   = idx_nxt + IDX_W'(1);
    end

    gnt_nxt = valid_nxt ? (N_REQ'(1) << idx_nxt) : '0;
  end

`ifdef HOLD_LIMIT_EN
  // Tenure counter: clears on a new grant or at the limit, counts every held cycle.
  always_comb begin
    cnt_nxt = '0;
    if (!grant_new && state == GRANT && state_nxt == GRANT) begin
      cnt_nxt = at_limit ? '0 : cnt + CNT_W'(1);
    end
  end

  // Tenure counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end
`endif

  // State, pointer and registered grant outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      gnt       <= '0;
    end else begin
      assert (HOLD_MAX >= 2 && HOLD_MAX <= 256);
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      gnt_idx   <= idx_nxt;
      gnt_valid <= valid_nxt;
      gnt       <= gnt_nxt;
    end
  end

endmodule

// File: tb/tb_round_robin_arbiter_4.sv
// tb_round_robin_arbiter_4: vector table plus hand-written multi-cycle sequences.
// Expected outputs are queued when stimulus is driven and checked after the edge.
module tb_round_robin_arbiter_4;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;

  int total;
  int bad;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       valid;
    string      name;
  } exp_t;

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       valid;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[12];

  round_robin_arbiter_4 #(.HOLD_MAX(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check_now(input logic [3:0] eg, input logic [1:0] ei, input logic ev,
                           input string nm);
    total++;
    if (gnt !== eg) begin
      bad++;
      $display("FAIL %s gnt: got %b required %b", nm, gnt, eg);
    end
    total++;
    if (gnt_idx !== ei) begin
      bad++;
      $display("FAIL %s gnt_idx: got %0d required %0d", nm, gnt_idx, ei);
    end
    total++;
    if (gnt_valid !== ev) begin
      bad++;
      $display("FAIL %s gnt_valid: got %b required %b", nm, gnt_valid, ev);
    end
  endtask

  task automatic pop_check();
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL scoreboard: got empty queue required an entry");
    end else begin
      e = sb.pop_front();
      check_now(e.gnt, e.idx, e.valid, e.name);
    end
  endtask

  // Drive one request vector, queue its expectation, check after the edge.
  task automatic step(input logic [3:0] r, input logic [3:0] eg, input logic [1:0] ei,
                      input logic ev, input string nm);
    exp_t e;
    @(negedge clk);
    req     = r;
    e.gnt   = eg;
    e.idx   = ei;
    e.valid = ev;
    e.name  = nm;
    sb.push_back(e);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req   = 4'b0000;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] eg;
    logic [1:0] ei;
    total = 0;
    bad   = 0;
    req   = 4'b0000;
    reset = 1'b0;
    #1 reset = 1'b1;
    #2;
    check_now(4'b0000, 2'd0, 1'b0, "reset_state");
    @(negedge clk);
    reset = 1'b0;

    // req, expected gnt, gnt_idx, gnt_valid
    vecs[0]  = '{4'b1010, 4'b0010, 2'd1, 1'b1};
    vecs[1]  = '{4'b1010, 4'b0010, 2'd1, 1'b1};
    vecs[2]  = '{4'b1000, 4'b1000, 2'd3, 1'b1};
    vecs[3]  = '{4'b0001, 4'b0001, 2'd0, 1'b1};
    vecs[4]  = '{4'b0000, 4'b0000, 2'd0, 1'b0};
    vecs[5]  = '{4'b0000, 4'b0000, 2'd0, 1'b0};
    vecs[6]  = '{4'b0100, 4'b0100, 2'd2, 1'b1};
    vecs[7]  = '{4'b0110, 4'b0100, 2'd2, 1'b1};
    vecs[8]  = '{4'b0011, 4'b0001, 2'd0, 1'b1};
    vecs[9]  = '{4'b0000, 4'b0000, 2'd0, 1'b0};
    vecs[10] = '{4'b1001, 4'b1000, 2'd3, 1'b1};
    vecs[11] = '{4'b0000, 4'b0000, 2'd3, 1'b0};
    for (int i = 0; i < 12; i++) begin
      step(vecs[i].req, vecs[i].gnt, vecs[i].idx, vecs[i].valid, $sformatf("vec%0d", i));
    end

    // Full contention with each owner releasing after two cycles: 0,1,2,3,0.
    do_reset();
    step(4'b1111, 4'b0001, 2'd0, 1'b1, "rr_first");
    for (int k = 0; k < 4; k++) begin
      eg = 4'b0001 << k;
      step(4'b1111, eg, 2'(k), 1'b1, $sformatf("rr_hold%0d", k));
      eg = 4'b0001 << ((k + 1) % 4);
      step(4'b1111 & ~(4'b0001 << k), eg, 2'((k + 1) % 4), 1'b1, $sformatf("rr_next%0d", k));
    end

    // Asynchronous reset while requester 2 owns the grant.
    do_reset();
    step(4'b0100, 4'b0100, 2'd2, 1'b1, "pre_reset");
    #2 reset = 1'b1;
    #1;
    check_now(4'b0000, 2'd0, 1'b0, "async_reset");
    req = 4'b1111;
    @(posedge clk);
    #1;
    check_now(4'b0000, 2'd0, 1'b0, "reset_held");
    @(negedge clk);
    reset = 1'b0;
    step(4'b1111, 4'b0001, 2'd0, 1'b1, "post_reset");

    // Two steady requesters: tenure limit alternates them every four cycles.
    do_reset();
    for (int i = 0; i < 16; i++) begin
`ifdef HOLD_LIMIT_EN
      ei = ((i / 4) % 2 == 0) ? 2'd0 : 2'd1;
`else
      ei = 2'd0;
`endif
      eg = 4'b0001 << ei;
      step(4'b0011, eg, ei, 1'b1, $sformatf("tenure%0d", i));
    end

    // Lone requester keeps the grant even when its tenure expires.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(4'b0100, 4'b0100, 2'd2, 1'b1, $sformatf("lone%0d", i));
    end

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d entries required 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
